// File: rtl/tsc_pkg.sv
// Shared definitions for the TSC readout receiver: widths, defaults and FSM encoding.
package tsc_pkg;

  localparam int unsigned TSC_SAMPLE_W    = 8;
  localparam int unsigned TSC_TS_W        = 32;
  localparam int unsigned TSC_NUM_SAMPLES = 32;
  localparam int unsigned TSC_RDY_TIMEOUT = 64;
  localparam int unsigned TSC_IDX_W       = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_WAIT_CD = 3'd2;
  localparam logic [2:0] ST_REQ     = 3'd3;
  localparam logic [2:0] ST_RECV    = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;
  localparam logic [2:0] ST_ERR     = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_ARMED   = ST_ARMED,
    S_WAIT_CD = ST_WAIT_CD,
    S_REQ     = ST_REQ,
    S_RECV    = ST_RECV,
    S_DONE    = ST_DONE,
    S_ERR     = ST_ERR
  } tsc_state_e;

endpackage

// File: rtl/tsc_sipo.sv
// Serial-to-parallel converter for the TSC stream: MSB-first shift register with a bit counter.
module tsc_sipo #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         rdy,
  input  logic         sd,
  output logic [W-1:0] word_c,
  output logic         load_done,
  output logic         mid_abort
);

  localparam int unsigned CW = $clog2(W);

  logic [W-2:0] shreg;
  logic [CW-1:0] cnt;

  // The completed word includes the bit being presented this cycle.
  assign word_c    = {shreg, sd};
  assign load_done = en & rdy & (cnt == CW'(W - 1));
  assign mid_abort = en & ~rdy & (cnt != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (rdy) begin
      shreg <= word_c[W-2:0];
      cnt   <= (cnt == CW'(W - 1)) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tsc_readout_rx.sv
// Host-side TSC readout: arm, wait for trigger and cache-done, request the buffer and deserialise it.
module tsc_readout_rx
  import tsc_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES = TSC_NUM_SAMPLES,
  parameter int unsigned SAMPLE_W    = TSC_SAMPLE_W,
  parameter int unsigned TS_W        = TSC_TS_W,
  parameter int unsigned RDY_TIMEOUT = TSC_RDY_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arm,
  input  logic                 trd,
  input  logic                 cd,
  input  logic [TS_W-1:0]      trigtm,
  input  logic                 rdy,
  input  logic                 sd,
  output logic                 sbf,
  output logic [SAMPLE_W-1:0]  sample,
  output logic                 sample_vld,
  output logic [TSC_IDX_W-1:0] sample_idx,
  output logic [TS_W-1:0]      trig_ts,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned TMO_W = $clog2(RDY_TIMEOUT + 1);

  tsc_state_e state, nxt;
  logic [TMO_W-1:0]     tmo_cnt;
  logic [TSC_IDX_W-1:0] idx;
  logic [SAMPLE_W-1:0]  word_c;
  logic                 load_done, mid_abort, in_rx, rearm;

  assign in_rx = (state == S_REQ) || (state == S_RECV);

  tsc_sipo #(.W(SAMPLE_W)) u_sipo (
    .clk       (clk),
    .reset     (reset),
    .en        (in_rx),
    .rdy       (rdy),
    .sd        (sd),
    .word_c    (word_c),
    .load_done (load_done),
    .mid_abort (mid_abort)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  // Next-state logic; arm only has an effect in IDLE, DONE and ERR.
  always_comb begin
    nxt   = state;
    rearm = 1'b0;
    case (state)
      S_IDLE:    if (arm) nxt = S_ARMED;
      S_ARMED:   if (trd) nxt = cd ? S_REQ : S_WAIT_CD;
      S_WAIT_CD: if (cd) nxt = S_REQ;
      S_REQ: begin
        if (rdy)                                 nxt = S_RECV;
        else if (tmo_cnt == TMO_W'(RDY_TIMEOUT)) nxt = S_ERR;
      end
      S_RECV: begin
        if (mid_abort)                                                  nxt = S_ERR;
        else if (load_done && (idx == TSC_IDX_W'(NUM_SAMPLES - 1)))     nxt = S_DONE;
      end
      S_DONE, S_ERR: if (arm) nxt = S_ARMED;
      default:   nxt = S_IDLE;
    endcase
    if ((nxt == S_ARMED) && (state != S_ARMED)) rearm = 1'b1;
  end

  // Registered outputs, timeout and index counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sbf        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      sample_vld <= 1'b0;
      sample     <= '0;
      sample_idx <= '0;
      trig_ts    <= '0;
      tmo_cnt    <= '0;
      idx        <= '0;
    end else begin
      sbf        <= (state == S_REQ) && (nxt == S_REQ);
      busy       <= nxt inside {S_ARMED, S_WAIT_CD, S_REQ, S_RECV};
      done       <= (nxt == S_DONE);
      err        <= (nxt == S_ERR);
      sample_vld <= load_done;
      if (state != S_REQ)                          tmo_cnt <= '0;
      else if (tmo_cnt != TMO_W'(RDY_TIMEOUT))     tmo_cnt <= tmo_cnt + TMO_W'(1);
      if ((state == S_ARMED) && trd) trig_ts <= trigtm;
      if (rearm) begin
        idx        <= '0;
        sample_idx <= '0;
      end else if (load_done) begin
        sample     <= word_c;
        sample_idx <= idx;
        if (idx != '1) idx <= idx + TSC_IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tsc_readout_rx.sv
// Scoreboard bench for tsc_readout_rx with a simple TSC serial-stream driver.
module tb_tsc_readout_rx;

  logic        clk = 1'b0;
  logic        reset, arm, trd, cd, rdy, sd;
  logic [31:0] trigtm;
  logic        sbf, sample_vld, busy, done, err;
  logic [7:0]  sample, sample_idx;
  logic [31:0] trig_ts;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] idx;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   vld_cnt = 0;
  int   base;
  int   k;

  always #5 clk = ~clk;

  tsc_readout_rx dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .trd        (trd),
    .cd         (cd),
    .trigtm     (trigtm),
    .rdy        (rdy),
    .sd         (sd),
    .sbf        (sbf),
    .sample     (sample),
    .sample_vld (sample_vld),
    .sample_idx (sample_idx),
    .trig_ts    (trig_ts),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Compare every produced sample against the oldest expected entry.
  always @(negedge clk) begin
    if (reset && sample_vld) begin
      vld_cnt++;
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sample", 32'(sample), 32'(e.d));
        check("sample_idx", 32'(sample_idx), 32'(e.idx));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_sbf();
    int n = 0;
    while (!sbf && n < 200) begin
      tick();
      n++;
    end
    check("sbf_seen", 32'(sbf), 32'd1);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      rdy = 1'b1;
      sd  = b[i];
      tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] ix);
    sb.push_back({b, ix});
    send_bits(b, 8);
  endtask

  task automatic burst(input logic [7:0] xorv, input int pause_after);
    for (int i = 0; i < 32; i++) begin
      send_byte(8'(i) ^ xorv, 8'(i));
      if (i == pause_after) begin
        rdy = 1'b0;
        sd  = 1'b1;
        repeat (3) tick();
      end
    end
    rdy = 1'b0;
  endtask

  task automatic end_check(input string tag, input int b);
    repeat (3) tick();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_vld_count"}, 32'(vld_cnt - b), 32'd32);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; arm = 1'b0; trd = 1'b0; cd = 1'b0; rdy = 1'b0; sd = 1'b0; trigtm = '0;
    @(negedge clk);
    check("rst_sbf", 32'(sbf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_vld", 32'(sample_vld), 32'd0);
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_idx", 32'(sample_idx), 32'd0);
    check("rst_ts", trig_ts, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    tick();

    // Stray rdy in IDLE is ignored.
    rdy = 1'b1; sd = 1'b1;
    repeat (4) tick();
    rdy = 1'b0;
    check("idle_stray_err", 32'(err), 32'd0);
    check("idle_stray_busy", 32'(busy), 32'd0);

    // 1: nominal burst, cd five clocks after trd.
    pulse_arm();
    check("t1_busy_armed", 32'(busy), 32'd1);
    trd = 1'b1; trigtm = 32'h0000_1234;
    repeat (5) tick();
    cd = 1'b1;
    wait_sbf();
    base = vld_cnt;
    burst(8'h00, -1);
    trd = 1'b0; cd = 1'b0; trigtm = 32'hDEAD_BEEF;
    end_check("t1", base);
    check("t1_trig_ts", trig_ts, 32'h0000_1234);

    // 2: simultaneous trd+cd goes straight to REQ; sbf follows one clock later.
    pulse_arm();
    check("t2_done_cleared", 32'(done), 32'd0);
    check("t2_busy", 32'(busy), 32'd1);
    trd = 1'b1; cd = 1'b1; trigtm = 32'hCAFE_0002;
    tick();
    check("t2_sbf_entry", 32'(sbf), 32'd0);
    check("t2_trig_ts", trig_ts, 32'hCAFE_0002);
    tick();
    check("t2_sbf_next", 32'(sbf), 32'd1);

    // 3: same burst with a 3-clock rdy gap between samples 4 and 5.
    base = vld_cnt;
    burst(8'hA5, 4);
    end_check("t3", base);

    // 4: rdy drops after three bits of sample 7.
    trd = 1'b0; cd = 1'b0;
    pulse_arm();
    trd = 1'b1; cd = 1'b1;
    wait_sbf();
    base = vld_cnt;
    for (int i = 0; i < 7; i++) send_byte(8'(i + 8'h50), 8'(i));
    send_bits(8'hFF, 3);
    rdy = 1'b0;
    repeat (2) tick();
    check("t4_err", 32'(err), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_sbf", 32'(sbf), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    check("t4_vld_count", 32'(vld_cnt - base), 32'd7);
    trd = 1'b0; cd = 1'b0;
    pulse_arm();
    check("t4_err_cleared", 32'(err), 32'd0);
    check("t4_rearmed", 32'(busy), 32'd1);

    // 5: no rdy after sbf -> err after the timeout.
    trd = 1'b1; cd = 1'b1;
    wait_sbf();
    k = 0;
    while (!err && k < 100) begin
      tick();
      k++;
    end
    check("t5_timeout_clks", 32'(k), 32'd64);
    check("t5_sbf_dropped", 32'(sbf), 32'd0);

    // 6: async reset during sample 10, then a clean burst.
    trd = 1'b0; cd = 1'b0;
    pulse_arm();
    trd = 1'b1; cd = 1'b1; trigtm = 32'h0000_0077;
    wait_sbf();
    for (int i = 0; i < 10; i++) send_byte(8'(i + 8'h80), 8'(i));
    send_bits(8'h0A, 4);
    #2 reset = 1'b0;
    #1;
    check("t6_sbf", 32'(sbf), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_err", 32'(err), 32'd0);
    check("t6_vld", 32'(sample_vld), 32'd0);
    check("t6_sample", 32'(sample), 32'd0);
    check("t6_idx", 32'(sample_idx), 32'd0);
    check("t6_ts", trig_ts, 32'd0);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);
    rdy = 1'b0; trd = 1'b0; cd = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    pulse_arm();
    trd = 1'b1; cd = 1'b1; trigtm = 32'h5555_AAAA;
    wait_sbf();
    base = vld_cnt;
    burst(8'h3C, -1);
    trd = 1'b0; cd = 1'b0;
    end_check("t6", base);
    check("t6_trig_ts", trig_ts, 32'h5555_AAAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
